// File: rtl/mem_bus_pkg.sv
// Shared types for the two-master native memory bus arbiter.
// State encoding, registered request bundle and master id.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        we;
  } mem_req_t;

  typedef logic mst_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick.
// On a tie the master that was not granted last wins.
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req_i,
  input  mst_id_t    last_grant_i,
  output logic       grant_valid_o,
  output mst_id_t    grant_id_o
);

  always_comb begin
    grant_valid_o = |req_i;
    grant_id_o    = 1'b0;
    unique case (req_i)
      2'b01:   grant_id_o = 1'b0;
      2'b10:   grant_id_o = 1'b1;
      2'b11:   grant_id_o = ~last_grant_i;
      default: grant_id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin front end for the native memory bus.
// One strobe per transaction; a silent slave yields an error pulse.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_wstrb,
  input  logic        m0_rstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_wstrb,
  input  logic        m1_rstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_wstrb,
  output logic        s_rstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_done,
  output logic        busy
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_e    state_q, state_d;
  mem_req_t      req_q, req_d;
  mst_id_t       gid_q, gid_d;
  mst_id_t       last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;

  logic [1:0]    req;
  logic          gnt_v;
  mst_id_t       gnt_id;
  logic [31:0]   rsp_data;

  assign req = {m1_wstrb | m1_rstrb, m0_wstrb | m0_rstrb};

  rr_arb2 u_rr (
    .req_i         (req),
    .last_grant_i  (last_q),
    .grant_valid_o (gnt_v),
    .grant_id_o    (gnt_id)
  );

  // last_q resets to 1 so master 0 wins the first tie
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      gid_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    gid_d   = gid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_v) begin
          state_d     = ISSUE;
          gid_d       = gnt_id;
          tmo_d       = 1'b0;
          req_d.addr  = gnt_id ? m1_addr  : m0_addr;
          req_d.wdata = gnt_id ? m1_wdata : m0_wdata;
          req_d.wmask = gnt_id ? m1_wmask : m0_wmask;
          req_d.we    = gnt_id ? m1_wstrb : m0_wstrb;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = s_done ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (s_done) begin
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          tmo_d   = 1'b1;
        end
      end
      RESP: begin
        last_d  = gid_q;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    m0_rdata = '0;
    m0_done  = 1'b0;
    m0_err   = 1'b0;
    m1_rdata = '0;
    m1_done  = 1'b0;
    m1_err   = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wmask  = '0;
    s_wstrb  = 1'b0;
    s_rstrb  = 1'b0;
    busy     = 1'b0;
    rsp_data = tmo_q    ? ERR_RDATA :
               req_q.we ? 32'h0     : s_rdata;
    if (state_q != IDLE) begin
      busy    = 1'b1;
      s_addr  = req_q.addr;
      s_wdata = req_q.wdata;
      s_wmask = req_q.wmask;
    end
    if (state_q == ISSUE) begin
      s_wstrb = req_q.we;
      s_rstrb = ~req_q.we;
    end
    if (state_q == RESP) begin
      if (gid_q) begin
        m1_done  = 1'b1;
        m1_err   = tmo_q;
        m1_rdata = rsp_data;
      end else begin
        m0_done  = 1'b1;
        m0_err   = tmo_q;
        m0_rdata = rsp_data;
      end
    end
  end

endmodule
